// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures memory data into a small queue
// and hands {inst, pc} pairs to decode over valid/ready. Redirects flush and reload.
module fetch_unit #(
  parameter int unsigned         PC_WIDTH = 64,
  parameter int unsigned         DEPTH    = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] pc,
  input  logic [31:0]         inst_in,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic [PC_WIDTH-1:0] out_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [31:0]         inst_mem_q [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem_q   [DEPTH];
  logic                pop_c;
  logic                push_c;

  assign pc        = pc_q;
  assign out_valid = (count_q != '0);
  assign out_inst  = inst_mem_q[rd_ptr_q];
  assign out_pc    = pc_mem_q[rd_ptr_q];

  // A full queue still accepts a new entry when the head leaves in the same cycle.
  assign pop_c  = out_valid & out_ready;
  assign push_c = ~redirect_valid & ((count_q < CNT_W'(DEPTH)) | pop_c);

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = redirect_target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        pc_d     = pc_q + PC_WIDTH'(1);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_c) begin
        inst_mem_q[wr_ptr_q] <= inst_in;
        pc_mem_q[wr_ptr_q]   <= pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-based reference model tracks expected PC and
// delivered {inst, pc} pairs, plus directed checks for the listed scenarios.
module tb_fetch_unit;

  localparam int unsigned PW = 64;

  logic          clock;
  logic          reset;
  logic [PW-1:0] pc;
  logic [31:0]   inst_in;
  logic          redirect_valid;
  logic [PW-1:0] redirect_target;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [PW-1:0] out_pc;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0]   inst;
    logic [PW-1:0] pc;
  } ent_t;

  ent_t          exp_q[$];
  logic [PW-1:0] model_pc;
  bit            model_live = 0;

  fetch_unit #(.PC_WIDTH(64), .DEPTH(2), .RESET_PC('0)) dut (
    .clock           (clock),
    .reset           (reset),
    .pc              (pc),
    .inst_in         (inst_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc)
  );

  function automatic logic [31:0] mem_f(input logic [PW-1:0] a);
    return 32'(a) + 32'h100;
  endfunction

  assign inst_in = mem_f(pc);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: compare current state, then advance with this cycle's inputs.
  always @(negedge clock) begin
    bit   pop;
    bit   push;
    ent_t e;
    if (model_live) begin
      check("model_pc", pc, model_pc);
      check("model_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("model_out_pc", out_pc, exp_q[0].pc);
        check("model_out_inst", 64'(out_inst), 64'(exp_q[0].inst));
      end
    end
    if (reset) begin
      exp_q.delete();
      model_pc   = '0;
      model_live = 1;
    end else if (redirect_valid) begin
      exp_q.delete();
      model_pc = redirect_target;
    end else begin
      pop  = (exp_q.size() != 0) && out_ready;
      push = (exp_q.size() < 2) || pop;
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        e.inst = mem_f(model_pc);
        e.pc   = model_pc;
        exp_q.push_back(e);
        model_pc = model_pc + 64'd1;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    step();
    step();
    check("rst_pc", pc, 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_inst", 64'(out_inst), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);

    // Streaming with decode always ready
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    check("stream_valid", 64'(out_valid), 64'd1);
    check("stream_out_pc", out_pc, 64'd0);
    check("stream_inst", 64'(out_inst), 64'h100);
    check("stream_pc", pc, 64'd1);
    repeat (4) step();
    check("stream_pc5", pc, 64'd5);
    check("stream_out_pc4", out_pc, 64'd4);

    // Backpressure: queue fills, pc stalls
    out_ready = 1'b0;
    repeat (4) step();
    check("stall_pc", pc, 64'd6);
    check("stall_out_pc", out_pc, 64'd4);
    check("stall_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    check("release_out_pc", out_pc, 64'd5);
    check("release_pc", pc, 64'd7);

    // Full queue with continuous pop+push
    repeat (3) step();
    check("full_pc", pc, 64'd10);
    check("full_out_pc", out_pc, 64'd8);

    // Redirect while full
    out_ready = 1'b0;
    repeat (2) step();
    redirect_valid  = 1'b1;
    redirect_target = 64'd9;
    out_ready       = 1'b1;
    step();
    check("redir_valid", 64'(out_valid), 64'd0);
    check("redir_pc", pc, 64'd9);
    redirect_valid = 1'b0;
    step();
    check("redir_out_valid", 64'(out_valid), 64'd1);
    check("redir_out_pc", out_pc, 64'd9);
    check("redir_out_inst", 64'(out_inst), 64'h109);

    // PC wrap at the top of the address space
    redirect_valid  = 1'b1;
    redirect_target = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    step();
    check("wrap_pc", pc, 64'd0);
    check("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_out_inst", 64'(out_inst), 64'hFF);
    step();
    check("wrap_out_pc0", out_pc, 64'd0);
    check("wrap_out_inst0", 64'(out_inst), 64'h100);

    // Back-to-back redirects: last one wins
    redirect_valid  = 1'b1;
    redirect_target = 64'd20;
    step();
    redirect_target = 64'd30;
    step();
    redirect_valid = 1'b0;
    step();
    check("b2b_pc", pc, 64'd31);
    check("b2b_out_pc", out_pc, 64'd30);

    // Reset beats redirect
    reset           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 64'd50;
    step();
    check("rst_redir_pc", pc, 64'd0);
    check("rst_redir_valid", 64'(out_valid), 64'd0);
    reset          = 1'b0;
    redirect_valid = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      out_ready       = 1'($urandom_range(0, 1));
      redirect_valid  = ($urandom_range(0, 15) == 0);
      redirect_target = {32'($urandom), 32'($urandom)};
      step();
    end
    redirect_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
